// File: rtl/mdu_div_iter.sv
// Iterative restoring divider for the EX-stage multiply/divide unit.
// STEPS quotient bits per CALC cycle; result is {remainder, quotient}, held until ack/start/annul.
module mdu_div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 ack_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 result_valid_o,
    output logic                 div_zero_o
);

    localparam int unsigned NCYC  = WIDTH / STEPS;
    localparam int unsigned CNT_W = $clog2(NCYC + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic               sign_mode;
    logic [WIDTH-1:0]   dvd_raw, dvs_raw;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH:0]     rem;
    logic [CNT_W-1:0]   count;
    logic               neg_q, neg_r, zero;

    logic               neg1, neg2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    logic [WIDTH:0]     step_rem, trial;
    logic [WIDTH-1:0]   step_quot;

    // Next-state logic; annul overrides everything, including a same-cycle start
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (start_i) begin
                state_nxt = PREP;
                accept    = 1'b1;
            end
            // zero divisor skips CALC but still spends one cycle in FIX
            PREP: state_nxt = (dvs_raw == '0) ? FIX : CALC;
            CALC: if (count == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: begin
                if (start_i) begin
                    state_nxt = PREP;
                    accept    = 1'b1;
                end else if (ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (annul_i) begin
            state_nxt = IDLE;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Operand magnitudes and sign fix-up
    always_comb begin
        neg1     = sign_mode & dvd_raw[WIDTH-1];
        neg2     = sign_mode & dvs_raw[WIDTH-1];
        mag1     = neg1 ? (~dvd_raw + WIDTH'(1)) : dvd_raw;
        mag2     = neg2 ? (~dvs_raw + WIDTH'(1)) : dvs_raw;
        quot_fix = neg_q ? (~quot + WIDTH'(1)) : quot;
        rem_fix  = neg_r ? (~rem[WIDTH-1:0] + WIDTH'(1)) : rem[WIDTH-1:0];
    end

    // STEPS restoring shift-subtract iterations, dividend shifted out of quot MSB-first
    always_comb begin
        step_rem  = rem;
        step_quot = quot;
        trial     = '0;
        for (int unsigned i = 0; i < STEPS; i++) begin
            step_rem  = {step_rem[WIDTH-1:0], step_quot[WIDTH-1]};
            step_quot = {step_quot[WIDTH-2:0], 1'b0};
            trial     = step_rem - {1'b0, dvs};
            if (!trial[WIDTH]) begin
                step_rem     = trial;
                step_quot[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_mode <= 1'b0;
            dvd_raw   <= '0;
            dvs_raw   <= '0;
            dvs       <= '0;
            quot      <= '0;
            rem       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (accept) begin
                sign_mode <= signed_div_i;
                dvd_raw   <= opdata1_i;
                dvs_raw   <= opdata2_i;
            end
            if (state == PREP) begin
                quot  <= mag1;
                dvs   <= mag2;
                rem   <= '0;
                count <= CNT_W'(NCYC);
                neg_q <= neg1 ^ neg2;
                neg_r <= neg1;
                zero  <= (dvs_raw == '0);
            end
            if (state == CALC) begin
                quot  <= step_quot;
                rem   <= step_rem;
                count <= count - CNT_W'(1);
            end
        end
    end

    // Registered status and result; result is loaded on FIX->DONE and held while DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_o        <= 1'b1;
            busy_o         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            div_zero_o     <= 1'b0;
        end else begin
            ready_o <= (state_nxt == IDLE) || (state_nxt == DONE);
            busy_o  <= (state_nxt == PREP) || (state_nxt == CALC) || (state_nxt == FIX);
            if (state_nxt != DONE) begin
                result_o       <= '0;
                result_valid_o <= 1'b0;
                div_zero_o     <= 1'b0;
            end else if (state == FIX) begin
                result_o       <= zero ? {dvd_raw, {WIDTH{1'b1}}} : {rem_fix, quot_fix};
                result_valid_o <= 1'b1;
                div_zero_o     <= zero;
            end
        end
    end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed bench for mdu_div_iter: one STEPS=1 and one STEPS=4 instance, 32-bit operands.
module tb_mdu_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_div [2];
    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic        start [2];
    logic        annul [2];
    logic        ack [2];
    logic        ready [2];
    logic        busy [2];
    logic [63:0] result [2];
    logic        valid [2];
    logic        dz [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_div_iter #(.WIDTH(32), .STEPS(1)) u_div1 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div[0]), .opdata1_i(op1[0]),
        .opdata2_i(op2[0]), .start_i(start[0]), .annul_i(annul[0]), .ack_i(ack[0]),
        .ready_o(ready[0]), .busy_o(busy[0]), .result_o(result[0]),
        .result_valid_o(valid[0]), .div_zero_o(dz[0])
    );

    mdu_div_iter #(.WIDTH(32), .STEPS(4)) u_div4 (
        .clk(clk), .rst(rst), .signed_div_i(signed_div[1]), .opdata1_i(op1[1]),
        .opdata2_i(op2[1]), .start_i(start[1]), .annul_i(annul[1]), .ack_i(ack[1]),
        .ready_o(ready[1]), .busy_o(busy[1]), .result_o(result[1]),
        .result_valid_o(valid[1]), .div_zero_o(dz[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one divide on instance k and check latency and result (no ack)
    task automatic do_div(input int k, input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dz, input int exp_lat);
        int lat;
        @(negedge clk);
        signed_div[k] = sgn;
        op1[k]        = a;
        op2[k]        = b;
        start[k]      = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        op1[k]   = 32'hDEADBEEF;
        op2[k]   = 32'h0;
        check({tag, " busy after accept"}, 64'(busy[k]), 64'd1);
        check({tag, " valid after accept"}, 64'(valid[k]), 64'd0);
        lat = 0;
        while (!valid[k] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result[k], {exp_r, exp_q});
        check({tag, " div_zero"}, 64'(dz[k]), 64'(exp_dz));
    endtask

    task automatic do_ack(input int k, input string tag);
        @(negedge clk);
        ack[k] = 1'b1;
        @(posedge clk);
        #1;
        ack[k] = 1'b0;
        check({tag, " valid after ack"}, 64'(valid[k]), 64'd0);
        check({tag, " result after ack"}, result[k], 64'd0);
        check({tag, " ready after ack"}, 64'(ready[k]), 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        for (int k = 0; k < 2; k++) begin
            signed_div[k] = 1'b0;
            op1[k] = '0;
            op2[k] = '0;
            start[k] = 1'b0;
            annul[k] = 1'b0;
            ack[k] = 1'b0;
        end
        #12;
        check("reset ready", 64'(ready[0]), 64'd1);
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset valid", 64'(valid[0]), 64'd0);
        check("reset result", result[0], 64'd0);
        check("reset dz", 64'(dz[0]), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_div(0, "u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        repeat (3) @(posedge clk);
        #1;
        check("u100/7 held result", result[0], {32'd2, 32'd14});
        check("u100/7 held valid", 64'(valid[0]), 64'd1);
        check("u100/7 ready in done", 64'(ready[0]), 64'd1);
        do_ack(0, "u100/7");
        check("u100/7 idle busy", 64'(busy[0]), 64'd0);

        do_div(0, "s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        do_ack(0, "s-7/2");
        do_div(0, "s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
        do_ack(0, "s7/-2");
        do_div(0, "uFFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 34);
        do_ack(0, "uFFFFFFF9/2");
        do_div(0, "div0", 1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2);
        do_ack(0, "div0");
        do_div(0, "sdiv0", 1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2);
        do_ack(0, "sdiv0");
        do_div(0, "ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
        do_ack(0, "ovf");

        // Annul during CALC cycle 10 with a competing start
        @(negedge clk);
        op1[0] = 32'd100;
        op2[0] = 32'd7;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul[0] = 1'b1;
        start[0] = 1'b1;
        op1[0] = 32'd1000;
        op2[0] = 32'd3;
        @(posedge clk);
        #1;
        annul[0] = 1'b0;
        start[0] = 1'b0;
        check("annul busy", 64'(busy[0]), 64'd0);
        check("annul ready", 64'(ready[0]), 64'd1);
        check("annul valid", 64'(valid[0]), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("annul start dropped", 64'(busy[0]), 64'd0);
        do_div(0, "after annul", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34);
        do_ack(0, "after annul");

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op1[0] = 32'd100;
        op2[0] = 32'd7;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async rst busy", 64'(busy[0]), 64'd0);
        check("async rst ready", 64'(ready[0]), 64'd1);
        check("async rst valid", 64'(valid[0]), 64'd0);
        check("async rst result", result[0], 64'd0);
        @(negedge clk);
        rst = 1'b1;
        do_div(0, "after reset", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        do_ack(0, "after reset");

        // STEPS=4 instance, then back-to-back issue from DONE without ack
        do_div(1, "s4 1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 10);
        for (int i = 0; i < 12; i++) begin
            rs = i[0];
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'd0) rb = 32'd5;
            if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
            if (rs) begin
                rq = $signed(ra) / $signed(rb);
                rr = $signed(ra) % $signed(rb);
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            do_div(1, $sformatf("s4 rnd%0d", i), rs, ra, rb, rq, rr, 1'b0, 10);
        end
        do_ack(1, "s4 final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
